// File: rtl/dq_dqs_oe_gen.sv
`default_nettype none
// ============================================================================
// Module   : dq_dqs_oe_gen
// Purpose  : DQ/DQS output-enable generator for the DDR PHY write path.
//            Turns per-phase DFI write-data enables into per-lane DQ and DQS
//            OE vectors. DQS preamble/postamble lengths are programmable, and
//            a write-levelling mode with a safe entry/exit handshake is
//            provided.
// Ports    : sclk, srst_n        - clock, async active-low reset
//            dfi_wrdata_en      - per-phase write-data enable (bit p = phase p)
//            cfg_dqs_pre/post   - DQS preamble/postamble in phases (clamped)
//            cfg_lane_en        - per-lane OE mask
//            wrlvl_req/ack      - write-levelling request / acknowledge
//            dq_oe, dqs_oe      - phase p at [p*IOG_DQS_LANES +: IOG_DQS_LANES]
//            stat_clr, stat_burst_cnt, stat_wl_viol
//                               - only when COREDDR_OE_STATS_EN is defined
// Options  : COREDDR_OE_STATS_EN - adds burst counter and WRLVL violation flag
// Revision : 1.0 - initial release
// ============================================================================
module dq_dqs_oe_gen #(
  parameter int NUM_PHASES    = 4,
  parameter int IOG_DQS_LANES = 9,
  parameter int DQ_DLY        = 1,
  parameter int MAX_POST      = 3,
  parameter int PRE_W         = 2,
  parameter int POST_W        = 2
) (
  input  logic                                  sclk,
  input  logic                                  srst_n,
  input  logic [NUM_PHASES-1:0]                 dfi_wrdata_en,
  input  logic [PRE_W-1:0]                      cfg_dqs_pre,
  input  logic [POST_W-1:0]                     cfg_dqs_post,
  input  logic [IOG_DQS_LANES-1:0]              cfg_lane_en,
  input  logic                                  wrlvl_req,
  output logic                                  wrlvl_ack,
`ifdef COREDDR_OE_STATS_EN
  input  logic                                  stat_clr,
  output logic [15:0]                           stat_burst_cnt,
  output logic                                  stat_wl_viol,
`endif
  output logic [NUM_PHASES*IOG_DQS_LANES-1:0]   dq_oe,
  output logic [NUM_PHASES*IOG_DQS_LANES-1:0]   dqs_oe
);

  localparam int c_HIST_W = DQ_DLY + MAX_POST;
  localparam int c_EXT_W  = c_HIST_W + NUM_PHASES;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_WL_PEND = 2'd1,
    ST_WRLVL   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_HIST_W-1:0]     r_hist;
  logic [c_HIST_W-1:0]     w_hist_nxt;
  logic [NUM_PHASES-1:0]   w_en_eff;
  logic [c_EXT_W-1:0]      w_ext;
  logic [c_HIST_W:0]       w_dmask;
  logic [NUM_PHASES-1:0]   w_dq_slot;
  logic [NUM_PHASES-1:0]   w_dqs_slot;
  logic                    w_wrlvl;
  int                      w_pre;
  int                      w_post;
  int                      w_lo;
  int                      w_hi;

  assign w_wrlvl = (r_state == ST_WRLVL);

  // Input is squashed while in reset (so a mid-burst reset kills OE at once)
  // and while write-levelling (DFI enables are ignored there).
  assign w_en_eff = (srst_n && !w_wrlvl) ? dfi_wrdata_en : '0;

  // Slot stream window: bit k is slot (cycle_start - c_HIST_W + k), so the
  // current phase p lives at c_HIST_W + p and r_hist holds the older slots.
  assign w_ext = {w_en_eff, r_hist};

  // The window slides by one cycle: keep the newest c_HIST_W slots.
  assign w_hist_nxt = w_wrlvl ? '0 : w_ext[NUM_PHASES +: c_HIST_W];

  // Clamped preamble/postamble and the resulting tap-distance range.
  always_comb begin
    w_pre  = (int'(cfg_dqs_pre)  > DQ_DLY)   ? DQ_DLY   : int'(cfg_dqs_pre);
    w_post = (int'(cfg_dqs_post) > MAX_POST) ? MAX_POST : int'(cfg_dqs_post);
    w_lo   = DQ_DLY - w_pre;
    w_hi   = DQ_DLY + w_post;
  end

  generate
    for (genvar d = 0; d <= c_HIST_W; d++) begin : g_dmask
      assign w_dmask[d] = (d >= w_lo) && (d <= w_hi);
    end

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
      // w_tap[d] = en[t - d] for this phase's slot t.
      logic [c_HIST_W:0] w_tap;
      for (genvar d = 0; d <= c_HIST_W; d++) begin : g_tap
        assign w_tap[d] = w_ext[c_HIST_W + p - d];
      end

      assign w_dq_slot[p]  = w_ext[c_HIST_W + p - DQ_DLY];
      assign w_dqs_slot[p] = |(w_tap & w_dmask);

      assign dq_oe[p*IOG_DQS_LANES +: IOG_DQS_LANES] =
        w_wrlvl ? '0 : ({IOG_DQS_LANES{w_dq_slot[p]}} & cfg_lane_en);
      assign dqs_oe[p*IOG_DQS_LANES +: IOG_DQS_LANES] =
        w_wrlvl ? cfg_lane_en : ({IOG_DQS_LANES{w_dqs_slot[p]}} & cfg_lane_en);
    end
  endgenerate

  // Write-levelling handshake: entry waits for the OE pipeline to drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (wrlvl_req) w_state_nxt = ST_WL_PEND;
      end
      ST_WL_PEND: begin
        if (!wrlvl_req)
          w_state_nxt = ST_NORMAL;
        else if ((r_hist == '0) && (dfi_wrdata_en == '0))
          w_state_nxt = ST_WRLVL;
      end
      ST_WRLVL: begin
        if (!wrlvl_req) w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_state <= ST_NORMAL;
      r_hist  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
    end
  end

  assign wrlvl_ack = w_wrlvl;

`ifdef COREDDR_OE_STATS_EN
  logic [NUM_PHASES-1:0] w_rise;
  logic [16:0]           w_cnt_sum;
  logic [15:0]           r_burst_cnt;
  logic                  r_wl_viol;

  generate
    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_rise
      // Previous slot of phase 0 is the newest history bit.
      assign w_rise[p] = w_ext[c_HIST_W + p] & ~w_ext[c_HIST_W + p - 1];
    end
  endgenerate

  always_comb begin
    w_cnt_sum = {1'b0, r_burst_cnt};
    for (int i = 0; i < NUM_PHASES; i++) begin
      w_cnt_sum = w_cnt_sum + {16'd0, w_rise[i]};
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_burst_cnt <= '0;
      r_wl_viol   <= 1'b0;
    end else if (stat_clr) begin
      r_burst_cnt <= '0;
      r_wl_viol   <= 1'b0;
    end else begin
      r_burst_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      if (w_wrlvl && (dfi_wrdata_en != '0)) r_wl_viol <= 1'b1;
    end
  end

  assign stat_burst_cnt = r_burst_cnt;
  assign stat_wl_viol   = r_wl_viol;
`endif

endmodule
`default_nettype wire
